mainreg_gen: RTL and testbench

Parametrised main register file for the SC8b CPU datapath. It holds DEPTH general registers of WIDTH bits and provides:
- one write port;
- two combinational operand read ports and a constant port;
- a single-cycle atomic register swap;
- a one-cycle shadow-bank save/restore for interrupt context switching.

It sits between the ALU result bus and the ALU operand inputs. Register DEPTH-1 serves as the index register.

---
 rtl/mainreg_gen.sv | 106 ++++++++++
 tb/tb_mainreg_gen.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mainreg_gen.sv
// mainreg_gen: SC8b main register file, two operand read ports, constant port, atomic swap, optional shadow bank.
// Latency: reads are combinational; write/swap/save/restore are visible right after the sampling CLK edge.
// Backpressure: none; one operation accepted every cycle, never busy.
// Optional feature: define MAINREG_SHADOW_EN to build the shadow bank (SAVE, RESTORE, SHVALID).
module mainreg_gen #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic [WIDTH-1:0]       IN,
    input  logic                   MRWE,
    input  logic [AW-1:0]          WA,
    input  logic [AW-1:0]          RA,
    input  logic [AW-1:0]          RB,
    input  logic                   RK,
    input  logic                   SWAPR,
    input  logic                   SAVE,
    input  logic                   RESTORE,
    output logic [WIDTH-1:0]       OUTA,
    output logic [WIDTH-1:0]       OUTB,
    output logic [WIDTH-1:0]       OUTK,
    output logic [WIDTH-1:0]       OIX,
    output logic [DEPTH*WIDTH-1:0] ORF,
    output logic                   SHVALID
);

    logic [WIDTH-1:0] regs     [DEPTH];
    logic [WIDTH-1:0] main_nxt [DEPTH];

    // Read side: everything comes straight from the main bank, no write bypass.
    assign OUTA = regs[RA];
    assign OUTB = regs[RB];
    assign OIX  = regs[DEPTH-1];
    assign OUTK = {WIDTH{RK}};

    for (genvar g = 0; g < DEPTH; g++) begin : g_flat
        assign ORF[g*WIDTH +: WIDTH] = regs[g];
    end

    // Ordinary main-bank update: swap wins over write; RA==RB swap is naturally a no-op.
    always_comb begin
        main_nxt = regs;
        if (SWAPR) begin
            main_nxt[RA] = regs[RB];
            main_nxt[RB] = regs[RA];
        end else if (MRWE) begin
            main_nxt[WA] = IN;
        end
    end

`ifdef MAINREG_SHADOW_EN
    logic [WIDTH-1:0] shadow [DEPTH];
    logic             shvalid_q;

    // Shadow bank snapshots the pre-edge main bank on any SAVE (alone or exchange);
    // a plain RESTORE consumes the saved context and clears the valid flag.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                shadow[i] <= '0;
            end
            shvalid_q <= 1'b0;
        end else if (SAVE) begin
            shadow    <= regs;
            shvalid_q <= 1'b1;
        end else if (RESTORE) begin
            shvalid_q <= 1'b0;
        end
    end

    // Main bank: any RESTORE (plain or exchange) loads the shadow and overrides swap/write.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (RESTORE) begin
            regs <= shadow;
        end else begin
            regs <= main_nxt;
        end
    end

    assign SHVALID = shvalid_q;
`else
    // Shadow controls have no effect in this build.
    logic unused_shadow_ctl;
    assign unused_shadow_ctl = SAVE ^ RESTORE;

    // Main bank: reset, then swap/write.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            regs <= main_nxt;
        end
    end

    assign SHVALID = 1'b0;
`endif

endmodule

// File: tb/tb_mainreg_gen.sv
// Testbench for mainreg_gen: an 8x4 instance and a 16x8 instance against a behavioural model.
// Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
// The model follows the shadow-bank build option the same way the design does.
module tb_mainreg_gen;

`ifdef MAINREG_SHADOW_EN
    localparam bit SH = 1'b1;
`else
    localparam bit SH = 1'b0;
`endif

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // ---------------- 8-bit x 4 instance ----------------
    logic        a_rst, a_we, a_rk, a_sw, a_sv, a_rs;
    logic [7:0]  a_in;
    logic [1:0]  a_wa, a_ra, a_rb;
    logic [7:0]  a_outa, a_outb, a_outk, a_oix;
    logic [31:0] a_orf;
    logic        a_shv;

    mainreg_gen #(.WIDTH(8), .DEPTH(4)) u_a (
        .CLK(clk), .RESET(a_rst), .IN(a_in), .MRWE(a_we), .WA(a_wa),
        .RA(a_ra), .RB(a_rb), .RK(a_rk), .SWAPR(a_sw), .SAVE(a_sv), .RESTORE(a_rs),
        .OUTA(a_outa), .OUTB(a_outb), .OUTK(a_outk), .OIX(a_oix), .ORF(a_orf), .SHVALID(a_shv)
    );

    // ---------------- 16-bit x 8 instance ----------------
    logic         b_rst, b_we, b_rk, b_sw, b_sv, b_rs;
    logic [15:0]  b_in;
    logic [2:0]   b_wa, b_ra, b_rb;
    logic [15:0]  b_outa, b_outb, b_outk, b_oix;
    logic [127:0] b_orf;
    logic         b_shv;

    mainreg_gen #(.WIDTH(16), .DEPTH(8)) u_b (
        .CLK(clk), .RESET(b_rst), .IN(b_in), .MRWE(b_we), .WA(b_wa),
        .RA(b_ra), .RB(b_rb), .RK(b_rk), .SWAPR(b_sw), .SAVE(b_sv), .RESTORE(b_rs),
        .OUTA(b_outa), .OUTB(b_outb), .OUTK(b_outk), .OIX(b_oix), .ORF(b_orf), .SHVALID(b_shv)
    );

    // ---------------- reference model ----------------
    logic [7:0]  ma [4];
    logic [7:0]  sa [4];
    bit          va;
    logic [15:0] mb [8];
    logic [15:0] sb [8];
    bit          vb;

    // One clock edge of the register file, told as a story of whole-bank moves.
    task automatic model_a(input bit rst, sv, rs, sw, we,
                           input logic [1:0] wa, input logic [7:0] din, input logic [1:0] ra, rb);
        logic [7:0] old_main [4];
        logic [7:0] tmp;
        if (rst) begin
            for (int i = 0; i < 4; i++) begin ma[i] = 8'h00; sa[i] = 8'h00; end
            va = 1'b0;
        end else if (SH && rs) begin
            old_main = ma;
            ma = sa;
            if (sv) begin sa = old_main; va = 1'b1; end
            else va = 1'b0;
        end else begin
            if (SH && sv) begin sa = ma; va = 1'b1; end
            if (sw) begin tmp = ma[ra]; ma[ra] = ma[rb]; ma[rb] = tmp; end
            else if (we) ma[wa] = din;
        end
    endtask

    task automatic model_b(input bit rst, sv, rs, sw, we,
                           input logic [2:0] wa, input logic [15:0] din, input logic [2:0] ra, rb);
        logic [15:0] old_main [8];
        logic [15:0] tmp;
        if (rst) begin
            for (int i = 0; i < 8; i++) begin mb[i] = 16'h0; sb[i] = 16'h0; end
            vb = 1'b0;
        end else if (SH && rs) begin
            old_main = mb;
            mb = sb;
            if (sv) begin sb = old_main; vb = 1'b1; end
            else vb = 1'b0;
        end else begin
            if (SH && sv) begin sb = mb; vb = 1'b1; end
            if (sw) begin tmp = mb[ra]; mb[ra] = mb[rb]; mb[rb] = tmp; end
            else if (we) mb[wa] = din;
        end
    endtask

    function automatic logic [31:0] exp_orf_a();
        return {ma[3], ma[2], ma[1], ma[0]};
    endfunction

    function automatic logic [127:0] exp_orf_b();
        logic [127:0] r;
        for (int i = 0; i < 8; i++) r[i*16 +: 16] = mb[i];
        return r;
    endfunction

    // Drive one operation on instance A across one clock, then step the model.
    task automatic cyc_a(input bit rst, sv, rs, sw, we,
                         input logic [1:0] wa, input logic [7:0] din, input logic [1:0] ra, rb);
        @(negedge clk);
        a_rst = rst; a_sv = sv; a_rs = rs; a_sw = sw; a_we = we;
        a_wa = wa; a_in = din; a_ra = ra; a_rb = rb;
        @(posedge clk);
        model_a(rst, sv, rs, sw, we, wa, din, ra, rb);
        #1;
        @(negedge clk);
        a_rst = 1'b0; a_sv = 1'b0; a_rs = 1'b0; a_sw = 1'b0; a_we = 1'b0;
    endtask

    task automatic cyc_b(input bit rst, sv, rs, sw, we,
                         input logic [2:0] wa, input logic [15:0] din, input logic [2:0] ra, rb);
        @(negedge clk);
        b_rst = rst; b_sv = sv; b_rs = rs; b_sw = sw; b_we = we;
        b_wa = wa; b_in = din; b_ra = ra; b_rb = rb;
        @(posedge clk);
        model_b(rst, sv, rs, sw, we, wa, din, ra, rb);
        #1;
        @(negedge clk);
        b_rst = 1'b0; b_sv = 1'b0; b_rs = 1'b0; b_sw = 1'b0; b_we = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        cyc_a(1, 0, 0, 0, 0, 2'd0, 8'h00, 2'd0, 2'd0);
        cyc_b(1, 0, 0, 0, 0, 3'd0, 16'h0, 3'd0, 3'd0);
        checks++; if (a_orf !== 32'h0) begin errors++; $display("FAIL reset_orf got=%h exp=00000000", a_orf); end
        checks++; if (a_shv !== 1'b0) begin errors++; $display("FAIL reset_shvalid got=%b exp=0", a_shv); end
        checks++; if (a_outa !== 8'h00 || a_outb !== 8'h00 || a_oix !== 8'h00)
            begin errors++; $display("FAIL reset_reads got=%h/%h/%h exp=00/00/00", a_outa, a_outb, a_oix); end
        checks++; if (b_orf !== 128'h0) begin errors++; $display("FAIL reset_orf16 got=%h exp=0", b_orf); end
    endtask

    task automatic test_write();
        // No bypass: during the write cycle OUTA still shows the old value.
        @(negedge clk);
        a_we = 1'b1; a_wa = 2'd0; a_in = 8'h11; a_ra = 2'd0;
        #1;
        checks++; if (a_outa !== 8'h00) begin errors++; $display("FAIL no_bypass got=%h exp=00", a_outa); end
        @(posedge clk);
        model_a(0, 0, 0, 0, 1, 2'd0, 8'h11, 2'd0, 2'd0);
        #1;
        checks++; if (a_outa !== 8'h11) begin errors++; $display("FAIL write_visible got=%h exp=11", a_outa); end
        @(negedge clk);
        a_we = 1'b0;
        cyc_a(0, 0, 0, 0, 1, 2'd1, 8'h22, 2'd0, 2'd0);
        cyc_a(0, 0, 0, 0, 1, 2'd2, 8'h33, 2'd0, 2'd0);
        cyc_a(0, 0, 0, 0, 1, 2'd3, 8'h44, 2'd0, 2'd0);
        a_ra = 2'd1; a_rb = 2'd2;
        #1;
        checks++; if (a_orf !== 32'h44332211) begin errors++; $display("FAIL write_orf got=%h exp=44332211", a_orf); end
        checks++; if (a_oix !== 8'h44) begin errors++; $display("FAIL write_oix got=%h exp=44", a_oix); end
        checks++; if (a_outa !== 8'h22 || a_outb !== 8'h33)
            begin errors++; $display("FAIL write_reads got=%h/%h exp=22/33", a_outa, a_outb); end
    endtask

    task automatic test_swap();
        cyc_a(0, 0, 0, 1, 1, 2'd1, 8'hFF, 2'd0, 2'd3);
        checks++; if (a_orf !== 32'h11332244) begin errors++; $display("FAIL swap_orf got=%h exp=11332244", a_orf); end
        cyc_a(0, 0, 0, 1, 0, 2'd0, 8'h00, 2'd2, 2'd2);
        checks++; if (a_orf !== 32'h11332244) begin errors++; $display("FAIL swap_same got=%h exp=11332244", a_orf); end
    endtask

    task automatic test_save_write();
        logic [7:0] exp0;
        cyc_a(0, 1, 0, 0, 1, 2'd0, 8'hAA, 2'd0, 2'd0);
        checks++; if (a_shv !== SH) begin errors++; $display("FAIL save_shvalid got=%b exp=%b", a_shv, SH); end
        checks++; if (a_orf[7:0] !== 8'hAA) begin errors++; $display("FAIL save_write got=%h exp=aa", a_orf[7:0]); end
        cyc_a(0, 0, 1, 0, 0, 2'd0, 8'h00, 2'd0, 2'd0);
        exp0 = SH ? 8'h44 : 8'hAA;
        checks++; if (a_orf[7:0] !== exp0) begin errors++; $display("FAIL restore_reg0 got=%h exp=%h", a_orf[7:0], exp0); end
        checks++; if (a_shv !== 1'b0) begin errors++; $display("FAIL restore_shvalid got=%b exp=0", a_shv); end
    endtask

    task automatic test_exchange();
        logic [7:0] exp2;
        cyc_a(0, 1, 0, 0, 0, 2'd0, 8'h00, 2'd0, 2'd0);
        cyc_a(0, 0, 0, 0, 1, 2'd2, 8'h5A, 2'd0, 2'd0);
        cyc_a(0, 1, 1, 1, 1, 2'd1, 8'hC3, 2'd0, 2'd1);
        exp2 = SH ? 8'h33 : 8'h5A;
        checks++; if (a_orf[23:16] !== exp2) begin errors++; $display("FAIL xchg_reg2 got=%h exp=%h", a_orf[23:16], exp2); end
        checks++; if (a_orf !== exp_orf_a()) begin errors++; $display("FAIL xchg_orf got=%h exp=%h", a_orf, exp_orf_a()); end
        checks++; if (a_shv !== SH) begin errors++; $display("FAIL xchg_shvalid got=%b exp=%b", a_shv, SH); end
        cyc_a(0, 0, 1, 0, 0, 2'd0, 8'h00, 2'd0, 2'd0);
        checks++; if (a_orf[23:16] !== 8'h5A) begin errors++; $display("FAIL xchg_back got=%h exp=5a", a_orf[23:16]); end
        checks++; if (a_shv !== 1'b0) begin errors++; $display("FAIL xchg_back_shv got=%b exp=0", a_shv); end
    endtask

    task automatic test_reset_mid();
        cyc_a(0, 1, 0, 0, 0, 2'd0, 8'h00, 2'd0, 2'd0);
        @(negedge clk);
        a_rst = 1'b1; a_sw = 1'b1; a_we = 1'b1; a_wa = 2'd3; a_in = 8'h77; a_ra = 2'd0; a_rb = 2'd3; a_rk = 1'b1;
        #1;
        checks++; if (a_outk !== 8'hFF) begin errors++; $display("FAIL outk_one_in_reset got=%h exp=ff", a_outk); end
        a_rk = 1'b0;
        #1;
        checks++; if (a_outk !== 8'h00) begin errors++; $display("FAIL outk_zero_in_reset got=%h exp=00", a_outk); end
        @(posedge clk);
        model_a(1, 0, 0, 1, 1, 2'd3, 8'h77, 2'd0, 2'd3);
        #1;
        checks++; if (a_orf !== 32'h0 || a_shv !== 1'b0)
            begin errors++; $display("FAIL reset_mid got=%h/%b exp=00000000/0", a_orf, a_shv); end
        @(negedge clk);
        a_rst = 1'b0; a_sw = 1'b0; a_we = 1'b0;
        // Restore right after reset copies the zeroed shadow bank.
        cyc_a(0, 0, 0, 0, 1, 2'd1, 8'h9C, 2'd0, 2'd0);
        cyc_a(0, 0, 1, 0, 0, 2'd0, 8'h00, 2'd0, 2'd0);
        checks++; if (a_orf !== exp_orf_a()) begin errors++; $display("FAIL restore_after_reset got=%h exp=%h", a_orf, exp_orf_a()); end
    endtask

    task automatic test_random();
        bit r, sv, rs, sw, we;
        for (int n = 0; n < 400; n++) begin
            r  = ($urandom_range(31) == 0);
            sv = ($urandom_range(5) == 0);
            rs = ($urandom_range(5) == 0);
            sw = ($urandom_range(3) == 0);
            we = 1'($urandom_range(1));
            a_rk = 1'($urandom_range(1));
            cyc_a(r, sv, rs, sw, we, 2'($urandom), 8'($urandom), 2'($urandom), 2'($urandom));
            checks++; if (a_orf !== exp_orf_a()) begin errors++; $display("FAIL rand_orf n=%0d got=%h exp=%h", n, a_orf, exp_orf_a()); end
            checks++; if (a_shv !== va) begin errors++; $display("FAIL rand_shv n=%0d got=%b exp=%b", n, a_shv, va); end
            checks++; if (a_outa !== ma[a_ra] || a_outb !== ma[a_rb] || a_oix !== ma[3])
                begin errors++; $display("FAIL rand_reads n=%0d got=%h/%h/%h exp=%h/%h/%h", n, a_outa, a_outb, a_oix, ma[a_ra], ma[a_rb], ma[3]); end
            checks++; if (a_outk !== {8{a_rk}}) begin errors++; $display("FAIL rand_outk n=%0d got=%h rk=%b", n, a_outk, a_rk); end
        end
    endtask

    task automatic test_params();
        bit sv, rs, sw, we;
        cyc_b(0, 0, 0, 0, 1, 3'd2, 16'h1234, 3'd0, 3'd0);
        cyc_b(0, 1, 0, 0, 0, 3'd0, 16'h0, 3'd0, 3'd0);
        cyc_b(0, 0, 0, 0, 1, 3'd2, 16'h0F0F, 3'd0, 3'd0);
        cyc_b(0, 0, 1, 0, 0, 3'd0, 16'h0, 3'd2, 3'd0);
        checks++; if (b_outa !== mb[2]) begin errors++; $display("FAIL p16_restore got=%h exp=%h", b_outa, mb[2]); end
        checks++; if (b_shv !== vb) begin errors++; $display("FAIL p16_shvalid got=%b exp=%b", b_shv, vb); end
        cyc_b(0, 0, 0, 0, 1, 3'd7, 16'hBEEF, 3'd7, 3'd0);
        checks++; if (b_oix !== 16'hBEEF) begin errors++; $display("FAIL p16_oix got=%h exp=beef", b_oix); end
        checks++; if (b_orf[127:112] !== 16'hBEEF) begin errors++; $display("FAIL p16_orf_top got=%h exp=beef", b_orf[127:112]); end
        b_rk = 1'b1;
        #1;
        checks++; if (b_outk !== 16'hFFFF) begin errors++; $display("FAIL p16_outk got=%h exp=ffff", b_outk); end
        for (int n = 0; n < 200; n++) begin
            sv = ($urandom_range(5) == 0);
            rs = ($urandom_range(5) == 0);
            sw = ($urandom_range(3) == 0);
            we = 1'($urandom_range(1));
            cyc_b(0, sv, rs, sw, we, 3'($urandom), 16'($urandom), 3'($urandom), 3'($urandom));
            checks++; if (b_orf !== exp_orf_b() || b_shv !== vb)
                begin errors++; $display("FAIL p16_rand n=%0d got=%h/%b exp=%h/%b", n, b_orf, b_shv, exp_orf_b(), vb); end
        end
    endtask

    initial begin
        a_rst = 1'b0; a_we = 1'b0; a_rk = 1'b0; a_sw = 1'b0; a_sv = 1'b0; a_rs = 1'b0;
        a_in = '0; a_wa = '0; a_ra = '0; a_rb = '0;
        b_rst = 1'b0; b_we = 1'b0; b_rk = 1'b0; b_sw = 1'b0; b_sv = 1'b0; b_rs = 1'b0;
        b_in = '0; b_wa = '0; b_ra = '0; b_rb = '0;
        test_reset();
        test_write();
        test_swap();
        test_save_write();
        test_exchange();
        test_reset_mid();
        test_random();
        test_params();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
